// File: rtl/conbus_led_bank.sv
// conbus_led_bank: Wishbone (conbus) slave driving a bank of debug LEDs.
// Each LED is either steady or blinks with a shared programmable half-period.
// Register map (word index = wb_adr_i[3:2]):
//   0 OUT    LED value
//   1 MODE   per-LED blink enable
//   2 PERIOD blink half-period in cycles (0 = blink off, phase held high)
//   3 STATUS read-only {phase at bit 31, leds in the low bits}
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-low reset
//   wb_adr_i/dat_i/sel_i/cyc_i/stb_i/we_i  bus request
//   wb_dat_o, wb_ack_o registered read data and single-cycle acknowledge
//   leds               registered LED drive
module conbus_led_bank #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned PRESCALE_W = 24,
  parameter logic [31:0] LED_INIT   = 32'h1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  output logic              wb_ack_o,
  output logic [N_LEDS-1:0] leds
);

  localparam int unsigned WCW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [N_LEDS-1:0]     out_q, out_d;
  logic [N_LEDS-1:0]     mode_q, mode_d;
  logic [N_LEDS-1:0]     leds_q, leds_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  logic        req_c;
  logic        wr_c;
  logic        per_wr_c;
  logic [1:0]  idx_c;
  logic [31:0] rd_data_c;
  logic        unused_adr_c;

  assign req_c        = wb_cyc_i & wb_stb_i;
  assign idx_c        = wb_adr_i[3:2];
  assign wr_c         = (state_q == ST_IDLE) & req_c & wb_we_i;
  assign per_wr_c     = wr_c & (idx_c == 2'd2) & (|wb_sel_i);
  assign unused_adr_c = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  // Replace the enabled byte lanes of a zero-extended register image.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Read mux; phase owns bit 31 of STATUS.
  always_comb begin
    rd_data_c = '0;
    case (idx_c)
      2'd0:    rd_data_c = 32'(out_q);
      2'd1:    rd_data_c = 32'(mode_q);
      2'd2:    rd_data_c = 32'(period_q);
      default: begin
        rd_data_c     = 32'(leds_q);
        rd_data_c[31] = phase_q;
      end
    endcase
  end

  // Bus FSM, register writes and read-data capture.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ack_d    = 1'b0;
    dat_d    = '0;
    out_d    = out_q;
    mode_d   = mode_q;
    period_d = period_q;

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (wb_we_i) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else if (READ_WAIT == 0) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            dat_d   = rd_data_c;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCW'(READ_WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          dat_d   = rd_data_c;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_c) begin
      case (idx_c)
        2'd0:    out_d    = N_LEDS'(lane_merge(32'(out_q), wb_dat_i, wb_sel_i));
        2'd1:    mode_d   = N_LEDS'(lane_merge(32'(mode_q), wb_dat_i, wb_sel_i));
        2'd2:    period_d = PRESCALE_W'(lane_merge(32'(period_q), wb_dat_i, wb_sel_i));
        default: ;
      endcase
    end
  end

  // Blink prescaler: a PERIOD write restarts the half-period with phase high.
  always_comb begin
    cnt_d   = cnt_q + PRESCALE_W'(1);
    phase_d = phase_q;
    if (per_wr_c || (period_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - PRESCALE_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  assign leds_d = (out_q & ~mode_q) | (out_q & mode_q & {N_LEDS{phase_q}});

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      out_q    <= LED_INIT[N_LEDS-1:0];
      mode_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      leds_q   <= LED_INIT[N_LEDS-1:0];
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      out_q    <= out_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      leds_q   <= leds_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_conbus_led_bank.sv
// Testbench for conbus_led_bank: a READ_WAIT=2 instance checked against a
// closed-form LED/phase model, plus a READ_WAIT=0 instance for latency and
// back-to-back acknowledge checks.
module tb_conbus_led_bank;

  localparam int RW_A = 2;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        wen;
  logic        cyc_a, stb_a, cyc_b, stb_b;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b;
  logic [7:0]  leds_a, leds_b;

  int edge_n = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  conbus_led_bank u_dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_a), .wb_sel_i(sel), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a),
    .wb_we_i(wen), .wb_ack_o(ack_a), .leds(leds_a)
  );

  conbus_led_bank #(.READ_WAIT(0)) u_dut_b (
    .sys_clk(clk), .sys_rst(sys_rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_b), .wb_sel_i(sel), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b),
    .wb_we_i(wen), .wb_ack_o(ack_b), .leds(leds_b)
  );

  // Model of instance A: register values before/after the latest write edge,
  // and blink phase derived from elapsed cycles since the last PERIOD write.
  logic [7:0] cur_out, old_out, cur_mode, old_mode;
  longint     cur_per, old_per, cur_tpw, old_tpw, w_edge;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [7:0] out_at(input longint k);
    return (k >= w_edge) ? cur_out : old_out;
  endfunction

  function automatic logic [7:0] mode_at(input longint k);
    return (k >= w_edge) ? cur_mode : old_mode;
  endfunction

  function automatic longint per_at(input longint k);
    return (k >= w_edge) ? cur_per : old_per;
  endfunction

  function automatic logic ph_at(input longint k);
    longint p, t;
    p = (k >= w_edge) ? cur_per : old_per;
    t = (k >= w_edge) ? cur_tpw : old_tpw;
    if (p == 0) return 1'b1;
    return (((k - t) / p) % 2) == 0;
  endfunction

  function automatic logic [7:0] leds_at(input longint k);
    logic [7:0] o, m;
    o = out_at(k - 1);
    m = mode_at(k - 1);
    return (o & ~m) | (o & m & {8{ph_at(k - 1)}});
  endfunction

  function automatic logic [31:0] rd_exp(input logic [1:0] idx, input longint e);
    logic [31:0] r;
    r = '0;
    case (idx)
      2'd0: r[7:0] = out_at(e - 1);
      2'd1: r[7:0] = mode_at(e - 1);
      2'd2: r[23:0] = 24'(per_at(e - 1));
      default: begin
        r[7:0] = leds_at(e - 1);
        r[31]  = ph_at(e - 1);
      end
    endcase
    return r;
  endfunction

  task automatic model_reset(input longint r);
    cur_out = 8'h01; old_out = 8'h01; cur_mode = '0; old_mode = '0;
    cur_per = 0; old_per = 0; cur_tpw = r; old_tpw = r; w_edge = r;
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [31:0] d,
                             input logic [3:0] s, input longint w);
    logic [31:0] m;
    old_out = cur_out; old_mode = cur_mode; old_per = cur_per; old_tpw = cur_tpw;
    case (idx)
      2'd0: begin m = merge({24'h0, cur_out}, d, s);  cur_out = m[7:0]; end
      2'd1: begin m = merge({24'h0, cur_mode}, d, s); cur_mode = m[7:0]; end
      2'd2: begin
        m = merge(32'(cur_per), d, s);
        cur_per = longint'(m[23:0]);
        if (s != 4'h0) cur_tpw = w;
      end
      default: ;
    endcase
    w_edge = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; checks ack latency, single-cycle ack and idle dat_o.
  task automatic wb(input int d, input logic we, input logic [1:0] idx,
                    input logic [31:0] data, input logic [3:0] s,
                    output logic [31:0] rdat, output int commit);
    bit got;
    int lat;
    @(negedge clk);
    adr = {28'h0, idx, 2'b00}; wdat = data; sel = s; wen = we;
    if (d == 0) begin cyc_a = 1'b1; stb_a = 1'b1; end
    else        begin cyc_b = 1'b1; stb_b = 1'b1; end
    @(posedge clk); #1;
    commit = edge_n;
    got = 1'b0; rdat = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((d == 0) ? ack_a : ack_b) begin
        got = 1'b1;
        rdat = (d == 0) ? dat_a : dat_b;
        break;
      end
    end
    lat = edge_n - commit;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(lat), (we || d != 0) ? 32'd0 : 32'(RW_A));
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    @(negedge clk);
    chk("ack_single", 32'((d == 0) ? ack_a : ack_b), 32'd0);
    chk("dat_idle", (d == 0) ? dat_a : dat_b, 32'd0);
  endtask

  // Idle cycles on instance A with per-cycle LED and ack checks.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("leds", 32'(leds_a), 32'(leds_at(edge_n)));
      chk("ack_idle", 32'(ack_a), 32'd0);
    end
  endtask

  task automatic wr_a(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int c;
    wb(0, 1'b1, idx, d, s, rd, c);
    model_write(idx, d, s, c);
  endtask

  task automatic rd_a(input logic [1:0] idx, output logic [31:0] rd);
    int c;
    wb(0, 1'b0, idx, 32'h0, 4'h0, rd, c);
    chk("read_model", rd, rd_exp(idx, c + RW_A));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d;
    logic [1:0]  idx;
    logic [3:0]  s;
    logic [5:0]  ackpat;
    int          c, cnt;

    sys_rst = 1'b0; adr = '0; wdat = '0; sel = '0; wen = 1'b0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;

    // Reset for two edges, then release.
    repeat (2) @(posedge clk);
    #1 model_reset(edge_n);
    @(negedge clk);
    sys_rst = 1'b1;
    chk("rst_leds", 32'(leds_a), 32'h01);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    idle(2);
    rd_a(2'd3, rd);
    chk("rst_status", rd, 32'h8000_0001);

    // Byte-lane write to OUT.
    wr_a(2'd0, 32'hFFFF_FFA5, 4'b0001);
    chk("lane_leds", 32'(leds_a), 32'hA5);
    idle(2);
    rd_a(2'd0, rd);
    chk("lane_readback", rd, 32'h0000_00A5);

    // Blink with half-period 4.
    wr_a(2'd0, 32'h0000_000F, 4'hF);
    wr_a(2'd1, 32'h0000_0003, 4'hF);
    wr_a(2'd2, 32'h0000_0004, 4'hF);
    idle(3);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (leds_a == 8'h0C) cnt++;
      else chk("blink_value", 32'(leds_a), 32'h0F);
    end
    chk("blink_low_count", 32'(cnt), 32'd4);
    idle(13);
    rd_a(2'd3, rd);
    wr_a(2'd2, 32'h0, 4'hF);
    idle(3);
    chk("period0_steady", 32'(leds_a), 32'h0F);
    idle(5);

    // Read abort: drop cyc while waiting.
    @(negedge clk);
    adr = 32'h4; wen = 1'b0; cyc_a = 1'b1; stb_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc_a = 1'b0; stb_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(ack_a);
    end
    chk("abort_no_ack", 32'(cnt), 32'd0);
    wr_a(2'd1, 32'h0000_00F0, 4'h1);
    idle(2);
    wr_a(2'd2, 32'h0000_0005, 4'h1);
    idle(4);

    // Reset asserted while a read waits.
    @(negedge clk);
    adr = 32'hC; wen = 1'b0; cyc_a = 1'b1; stb_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_ack", 32'(ack_a), 32'd0);
    sys_rst = 1'b0;
    @(posedge clk); #1;
    model_reset(edge_n);
    @(negedge clk);
    chk("midrst_ack", 32'(ack_a), 32'd0);
    chk("midrst_leds", 32'(leds_a), 32'h01);
    sys_rst = 1'b1; cyc_a = 1'b0; stb_a = 1'b0;
    idle(4);
    rd_a(2'd0, rd); chk("midrst_out", rd, 32'h1);
    rd_a(2'd1, rd); chk("midrst_mode", rd, 32'h0);
    rd_a(2'd2, rd); chk("midrst_period", rd, 32'h0);

    // Zero-wait instance: read latency and back-to-back writes.
    wb(1, 1'b1, 2'd1, 32'h1234_56C3, 4'b0001, rd, c);
    wb(1, 1'b0, 2'd1, 32'h0, 4'h0, rd, c);
    chk("b_read_mode", rd, 32'h0000_00C3);
    @(negedge clk);
    adr = 32'h0; wdat = 32'h0000_003C; sel = 4'h1; wen = 1'b1; cyc_b = 1'b1; stb_b = 1'b1;
    ackpat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ackpat = {ackpat[4:0], ack_b};
    end
    cyc_b = 1'b0; stb_b = 1'b0;
    chk("b_b2b_acks", 32'(ackpat), 32'b101010);
    @(negedge clk);
    chk("b_leds", 32'(leds_b), 32'h3C);

    // Randomized traffic on instance A.
    for (int i = 0; i < 60; i++) begin
      idx = 2'($urandom_range(0, 3));
      s   = 4'($urandom);
      d   = $urandom;
      if (idx == 2'd2) d = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 9) < 6) wr_a(idx, d, s);
      else rd_a(idx, rd);
      idle($urandom_range(1, 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conbus_led_bank.md
Name: conbus_led_bank

Overview:
Parametrised Wishbone (conbus) slave driving a bank of N debug LEDs, with per-LED steady or blink mode, byte-lane writes and a configurable read wait-state count. It sits on a conbus slave port next to the other CSR-style peripherals. Bring-up code gets a visible heartbeat and status pattern without CPU polling.

Parameters:
N_LEDS, 8, number of LED outputs (1..32)
READ_WAIT, 2, wait cycles between read request and ack (0..7)
PRESCALE_W, 24, width of blink period register/counter (1..32)
LED_INIT, 32'h1, reset value of OUT register (low N_LEDS bits used)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-low (0 = reset)
wb_adr_i  in  32  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_sel_i  in  4  byte-lane enables for writes
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write
wb_ack_o  out  1  single-cycle acknowledge, registered
leds  out  N_LEDS  LED drive, registered

Behaviour:
- Registers (word index = wb_adr_i[3:2]): 0 OUT[N-1:0] LED value; 1 MODE[N-1:0] per-LED blink enable; 2 PERIOD[PRESCALE_W-1:0] blink half-period in cycles; 3 STATUS read-only = {phase in bit 31, leds in low N bits}; writes to 3 ignored. Unimplemented bits read 0.
- Reset (sys_rst=0 at clock edge): state IDLE, wb_ack_o=0, wb_dat_o=0, OUT=LED_INIT, MODE=0, PERIOD=0, counter=0, phase=1, leds=LED_INIT[N-1:0]. Reset mid-transaction drops it: no ack, no register update.
- FSM states IDLE, WAIT, ACK.
- IDLE: on cyc&stb&we, commit write with byte lanes per wb_sel_i in that same edge, go ACK. On cyc&stb&!we: go WAIT if READ_WAIT>0 with wait counter=READ_WAIT-1, else go ACK.
- WAIT: if !cyc, abort to IDLE without ack. If wait counter==0, go ACK; else decrement.
- Read data is sampled from registers at the edge entering ACK and held in wb_dat_o while in ACK. wb_dat_o is 0 in all other states.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE unconditionally. Write latency is 1 cycle (ack in cycle after request). Read latency is READ_WAIT+1 cycles.
- stb asserted without cyc is ignored. Back-to-back requests are accepted in the IDLE cycle after ACK.
- Blink: when PERIOD≠0, counter increments each cycle. When counter==PERIOD-1 it wraps to 0 and phase toggles. When PERIOD==0, counter is held 0 and phase is held 1.
- Any write to PERIOD (any lane enabled) clears counter to 0 and sets phase=1 on the same edge.
- leds[i] <= MODE[i] ? (OUT[i] & phase) : OUT[i]. One cycle after the register/phase change.
- Simultaneous write to OUT/MODE and phase toggle: both take effect on the same edge; leds reflect the new values one cycle later.

Test Plan:
- Reset: hold sys_rst=0 for 2 cycles, release -> leds=8'h01, wb_ack_o=0. Read idx3 -> 32'h8000_0001 after READ_WAIT+1=3 cycles with a single ack pulse.
- Byte-lane write: write idx0 data 32'hFFFF_FFA5 with sel=4'b0001 -> ack 1 cycle later. leds=8'hA5 the following cycle. Readback idx0 = 32'h0000_00A5.
- Blink: OUT=8'h0F, MODE=8'h03, PERIOD=4 -> leds alternate 8'h0F and 8'h0C every 4 cycles. Writing PERIOD=0 -> leds steady at 8'h0F.
- Read abort: start read, drop cyc in WAIT -> no ack, FSM back in IDLE. Next write is acked normally.
- Mid-op reset: assert sys_rst=0 during WAIT -> no ack; all registers return to reset values.
- READ_WAIT=0 build: read idx1 -> ack in the next cycle with the correct data. Back-to-back writes are each acked once, with 1 idle cycle between acks.
